// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// fetch_entry_t is sized by the package defaults; the top parameters default to the same values.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned INSTR_BYTES = 4;
  // Stale responses can outnumber FIFO slots after repeated redirects, so drop gets extra headroom.
  localparam int unsigned DROP_W      = 8;

  typedef enum logic [0:0] {
    BOOT,
    FETCH
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries with push, pop and flush.
// A flush clears the FIFO and takes priority over a push or pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     push_entry,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A pop on a full FIFO frees the head slot at the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= push_entry;
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, credit-limited memory requests, prefetch FIFO and redirect handling.
// Responses are tagged from a shadow PC counter since kept responses are contiguous in address.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned      ADDR_W     = ADDR_W_DEF,
  parameter int unsigned      DATA_W     = DATA_W_DEF,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [DATA_W-1:0] if_decoder_instruction,
  output logic [ADDR_W-1:0] if_decoder_pc,
  output logic              if_decoder_valid,
  input  logic              decoder_if_ready
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned USED_W = CNT_W + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [ADDR_W-1:0] target;
  logic [CNT_W-1:0]  fifo_count;
  logic [USED_W-1:0] used;
  logic              fifo_full;
  logic              fifo_empty;
  logic              req_accept;
  logic              rsp_keep;
  logic              rsp_retire;
  logic              dec_pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic              unused_bits;

  assign target       = {branch_target[ADDR_W-1:2], 2'b00};
  assign unused_bits  = ^{branch_target[1:0], fifo_full};
  assign used         = USED_W'(fifo_count) + USED_W'(inflight_q);

  // Every accepted request already owns a FIFO slot, so a kept response can always be pushed.
  assign imem_req_valid = (state_q == FETCH) && (used < USED_W'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_accept     = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !branch_valid;
  assign rsp_retire     = imem_rsp_valid && ((drop_q != '0) || (inflight_q != '0));
  assign dec_pop        = if_decoder_valid && decoder_if_ready;

  always_comb begin
    push_entry       = '0;
    push_entry.instr = DATA_W_DEF'(imem_rsp_data);
    push_entry.pc    = ADDR_W_DEF'(rsp_pc_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;

    unique case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      default: state_d = BOOT;
    endcase

    if (branch_valid) begin
      // Everything outstanding, plus a request accepted now, belongs to the old path.
      pc_d       = target;
      rsp_pc_d   = target;
      inflight_d = '0;
      drop_d     = drop_q + DROP_W'(inflight_q) + DROP_W'(req_accept) - DROP_W'(rsp_retire);
    end else begin
      if (req_accept) pc_d = pc_q + ADDR_W'(INSTR_BYTES);
      if (rsp_keep)   rsp_pc_d = rsp_pc_q + ADDR_W'(INSTR_BYTES);
      inflight_d = inflight_q + CNT_W'(req_accept) - CNT_W'(rsp_keep);
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - DROP_W'(1);
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rsp_keep),
    .pop        (dec_pop),
    .flush      (branch_valid),
    .push_entry (push_entry),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign if_decoder_valid       = !fifo_empty;
  assign if_decoder_instruction = if_decoder_valid ? DATA_W'(head.instr) : '0;
  assign if_decoder_pc          = if_decoder_valid ? ADDR_W'(head.pc) : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: fixed-latency memory model, random stalls and redirects.
module tb_instr_fetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        branch_valid   = 1'b0;
  logic [31:0] branch_target  = '0;
  logic [31:0] if_decoder_instruction;
  logic [31:0] if_decoder_pc;
  logic        if_decoder_valid;
  logic        decoder_if_ready = 1'b1;

  instr_fetch #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RPC)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .imem_req_valid         (imem_req_valid),
    .imem_req_addr          (imem_req_addr),
    .imem_req_ready         (imem_req_ready),
    .imem_rsp_valid         (imem_rsp_valid),
    .imem_rsp_data          (imem_rsp_data),
    .branch_valid           (branch_valid),
    .branch_target          (branch_target),
    .if_decoder_instruction (if_decoder_instruction),
    .if_decoder_pc          (if_decoder_pc),
    .if_decoder_valid       (if_decoder_valid),
    .decoder_if_ready       (decoder_if_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mem_t        mem_q[$];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          since_rel = 0;
  int          lat      = 1;
  int          rmode    = 0;  // 0 ready, 1 toggle, 2 random
  int          dmode    = 0;  // 0 ready, 1 stalled, 2 random
  int          acc_cnt  = 0;
  int          delivered = 0;
  logic [31:0] model_pc = RPC;
  logic [31:0] last_acc = '1;
  logic        wrap_seen = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5a5a_c3c3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Input driver and memory response path.
  always @(posedge clk) begin
    mem_t m;
    cyc++;
    since_rel = rst ? 0 : since_rel + 1;
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst) mem_q.delete();
    else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m.addr);
    end
    case (rmode)
      0:       imem_req_ready = 1'b1;
      1:       imem_req_ready = ~imem_req_ready;
      default: imem_req_ready = 1'($urandom_range(0, 1));
    endcase
    case (dmode)
      0:       decoder_if_ready = 1'b1;
      1:       decoder_if_ready = 1'b0;
      default: decoder_if_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Memory accepts every handshaken request, stale or not.
  always @(negedge clk) begin
    if (!rst && imem_req_valid && imem_req_ready)
      mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
  end

  // Reference model: kept requests form a contiguous stream from the last restart point.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
      model_pc = RPC;
    end else if (branch_valid) begin
      if (imem_req_valid && imem_req_ready) acc_cnt++;
      exp_q.delete();
      model_pc = {branch_target[31:2], 2'b00};
    end else if (imem_req_valid && imem_req_ready) begin
      acc_cnt++;
      check("req_addr", imem_req_addr, model_pc);
      if (last_acc == 32'hffff_fffc && imem_req_addr == 32'h0) wrap_seen = 1'b1;
      last_acc = imem_req_addr;
      exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  end

  // Monitor: credits, address stability and delivered words.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_req_addr", imem_req_addr, RPC);
      check("rst_dec_valid", {31'b0, if_decoder_valid}, 32'd0);
      check("rst_dec_instr", if_decoder_instruction, 32'd0);
      check("rst_dec_pc", if_decoder_pc, 32'd0);
      prev_hold = 1'b0;
    end else begin
      if (since_rel >= 1)
        check("req_credit", {31'b0, imem_req_valid}, {31'b0, (exp_q.size() < DEPTH)});
      else
        check("boot_no_req", {31'b0, imem_req_valid}, 32'd0);
      if (prev_hold && imem_req_valid) check("addr_stable", imem_req_addr, prev_addr);
      prev_hold = imem_req_valid && !imem_req_ready && !branch_valid;
      prev_addr = imem_req_addr;
      if (if_decoder_valid && decoder_if_ready && !branch_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word_pc", if_decoder_pc, 32'hdead_beef);
        end else begin
          e = exp_q.pop_front();
          delivered++;
          check("dec_pc", if_decoder_pc, e.pc);
          check("dec_instr", if_decoder_instruction, e.instr);
        end
      end
    end
  end

  task automatic do_reset(input int l);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_same_cycle_dec_valid", {31'b0, if_decoder_valid}, 32'd0);
    check("rst_same_cycle_req_valid", {31'b0, imem_req_valid}, 32'd0);
    lat = l;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    acc_cnt = 0;
  endtask

  // Drives a redirect for n consecutive cycles, each with its own target.
  task automatic do_branch(input logic [31:0] t, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      branch_valid  = 1'b1;
      branch_target = t + 32'(i * 64);
    end
    @(posedge clk);
    #1 branch_valid = 1'b0;
  endtask

  initial begin
    int first;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    acc_cnt = 0;

    // First delivered word appears three cycles after release.
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (if_decoder_valid && first < 0) first = k;
    end
    check("first_valid_cycle", 32'(first), 32'd3);
    repeat (20) @(posedge clk);

    // Decoder stalled: exactly DEPTH requests, head held at pc 0.
    dmode = 1;
    do_reset(1);
    repeat (12) @(posedge clk);
    #2;
    check("stall_req_count", 32'(acc_cnt), 32'(DEPTH));
    check("stall_head_valid", {31'b0, if_decoder_valid}, 32'd1);
    check("stall_head_pc", if_decoder_pc, 32'h0);
    dmode = 0;
    repeat (20) @(posedge clk);

    // Redirect with two requests in flight at latency 3.
    do_reset(3);
    repeat (2) @(posedge clk);
    do_branch(32'h103, 1);
    repeat (30) @(posedge clk);

    // Redirect coinciding with pop, accept and response in steady state.
    do_reset(1);
    repeat (10) @(posedge clk);
    do_branch(32'h200, 1);
    repeat (15) @(posedge clk);
    do_branch(32'h301, 2);
    repeat (20) @(posedge clk);

    // Toggling ready, random decoder stalls, wrap through the top of the address space.
    rmode = 1;
    dmode = 2;
    do_branch(32'hffff_fff0, 1);
    repeat (60) @(posedge clk);
    check("pc_wrapped", {31'b0, wrap_seen}, 32'd1);

    // Reset mid-stream with entries buffered.
    rmode = 0;
    dmode = 1;
    repeat (6) @(posedge clk);
    do_reset(1);
    dmode = 0;
    repeat (20) @(posedge clk);

    // Randomized segments.
    for (int seg = 0; seg < 3; seg++) begin
      rmode = 2;
      dmode = 2;
      do_reset($urandom_range(1, 3));
      for (int i = 0; i < 150; i++) begin
        @(posedge clk);
        if ($urandom_range(0, 11) == 0)
          do_branch($urandom_range(0, 32'h3ff), $urandom_range(1, 2));
      end
    end

    check("progress", {31'b0, (delivered > 100)}, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the decoder in processor_top; produces if_decoder_instruction.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents them to the decoder with a valid/ready handshake.
- Applies branch redirects from execute: flushes the FIFO and discards stale in-flight responses.

Parameters:
- ADDR_W, 32, PC/address width
- DATA_W, 32, instruction width
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2
- RESET_PC, 0, first fetch address; word-aligned

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  ADDR_W  fetch address (= PC)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response word valid; in request order, latency ≥1 cycle
- imem_rsp_data  in  DATA_W  response word
- branch_valid  in  1  redirect request, single-cycle pulse
- branch_target  in  ADDR_W  redirect address; bits [1:0] ignored and forced to 0
- if_decoder_instruction  out  DATA_W  FIFO head instruction
- if_decoder_pc  out  ADDR_W  address of head instruction
- if_decoder_valid  out  1  head entry valid
- decoder_if_ready  in  1  decoder consumes head when valid & ready

Behaviour:
- Reset (async assert, sync release):
  - PC = RESET_PC; FIFO empty; inflight = 0; drop = 0; FSM = BOOT.
  - Outputs: imem_req_valid = 0, imem_req_addr = RESET_PC, if_decoder_valid = 0, instruction/pc = 0.
  - Reset mid-operation discards everything; responses arriving after reset are not counted (memory is reset too).
- FSM:
  - BOOT: one cycle with no request, then FETCH.
  - FETCH: imem_req_valid = 1 while credits are available.
  - Credit rule: fifo_count + inflight < FIFO_DEPTH, where inflight counts accepted requests whose responses are still pending and will be kept.
- Request accept (valid & ready): PC += 4, wrapping mod 2^ADDR_W; inflight += 1. Address is stable while valid & !ready, except on redirect.
- Response, when drop > 0: word discarded; drop -= 1.
- Response, when drop = 0: word pushed with its PC; inflight -= 1. Entry PCs come from a small PC queue or a shadow counter.
- Pop (if_decoder_valid & decoder_if_ready): head advances. Push and pop in the same cycle leave the count unchanged, including when full.
- Latency: request accepted at cycle N, response at N+L → if_decoder_valid at N+L+1 (registered FIFO output). No combinational path from imem_rsp to if_decoder outputs.
- Redirect (branch_valid = 1), applied next edge:
  - PC = {branch_target[ADDR_W-1:2], 2'b00}.
  - FIFO flushed; if_decoder_valid = 0 next cycle.
  - drop += inflight; inflight = 0.
  - A request accepted in the same cycle is stale: drop += 1 more.
  - A pop in the same cycle is ignored; flush wins.
  - A response in the same cycle is discarded if drop > 0 or counted into drop; it is never delivered.
  - The first request to the target is issued the cycle after the redirect. FSM stays in FETCH.
- Back-to-back redirects: the later one wins; drop accumulates and never underflows.
- Full FIFO with decoder stalled: no new requests. Every accepted request has a guaranteed FIFO slot, so no overflow is possible.

Decomposition:
- Package fetch_pkg:
  - FSM enum {BOOT, FETCH}.
  - ADDR_W / DATA_W defaults and INSTR_BYTES = 4.
  - fetch_entry_t struct {instr, pc}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, full, empty, parameterised by FIFO_DEPTH.

Test Plan:
- Reset, memory with L = 1 always ready, decoder always ready → requests at 0x0, 0x4, 0x8, …; if_decoder_pc sequence 0x0, 0x4, 0x8 with matching data; first valid 3 cycles after reset release.
- Decoder ready held 0 for 10 cycles, L = 1 → exactly 4 requests issued; if_decoder_valid stays 1 with pc 0x0; no overflow; on ready=1, pcs 0x0–0xC then 0x10 resumes.
- L = 3, redirect to 0x103 with 2 requests in flight → both stale responses dropped; next request addr 0x100; first delivered pc 0x100.
- Redirect in the same cycle as pop, request accept, and response → none of those words reach the decoder; drop count correct; first delivered pc = target.
- imem_req_ready toggling 1010…, random decoder stalls, RESET_PC = 0xFFFFFFF8 → address stable while unaccepted; PC wraps 0xFFFFFFFC → 0x0; pcs delivered in order with no gaps or duplicates.
- Assert rst mid-stream with 3 entries buffered → same cycle: if_decoder_valid = 0 and imem_req_valid = 0; after release, fetching restarts at RESET_PC.
